// File: rtl/window_apply.sv
// Windowing stage: frame sample x run-time loadable coefficient, zero-padded to NFFT_SIZE.
// Optional build macro WINDOW_ROUND_SAT_EN selects round-half-up with saturation instead of truncate/wrap.
module window_apply #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int COEF_WIDTH   = 16,
  parameter int COEF_FRAC    = 15,
  parameter int FRAME_LEN    = 306,
  parameter int NFFT_SIZE    = 512,
  parameter int PTR_W        = $clog2(NFFT_SIZE)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start_i,
  output logic                           busy_o,
  output logic                           rd_en_o,
  output logic [PTR_W-1:0]               frame_ptr_o,
  input  logic                           sample_valid_i,
  input  logic signed [SAMPLE_WIDTH-1:0] frame_sample_i,
  input  logic                           coef_we_i,
  input  logic [PTR_W-1:0]               coef_addr_i,
  input  logic signed [COEF_WIDTH-1:0]   coef_data_i,
  output logic signed [SAMPLE_WIDTH-1:0] out_sample_o,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic                           out_last_o,
  output logic                           done_o
);

  localparam int IDX_W = PTR_W + 1;
  localparam int CA_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int PW    = SAMPLE_WIDTH + COEF_WIDTH;

  localparam logic [IDX_W-1:0] FRAME_END  = IDX_W'(FRAME_LEN);
  localparam logic [IDX_W-1:0] FETCH_LAST = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] PAD_LAST   = IDX_W'(NFFT_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_PAD,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic                            pending_q, pending_d;
  logic signed [SAMPLE_WIDTH-1:0]  out_sample_q, out_sample_d;
  logic                            out_valid_q, out_valid_d;
  logic                            out_last_q, out_last_d;

  logic                            out_xfer;
  logic                            out_free;
  logic                            coef_wr;
  logic signed [COEF_WIDTH-1:0]    coef_rd;
  logic signed [PW-1:0]            product;
  logic signed [SAMPLE_WIDTH-1:0]  win_sample;

  logic signed [COEF_WIDTH-1:0]    coef_mem [FRAME_LEN];

  assign out_xfer = out_valid_q && out_ready_i;
  assign out_free = !out_valid_q || out_ready_i;

  // Loads are only allowed while idle so a frame always sees one consistent window.
  assign coef_wr = coef_we_i && (state_q == S_IDLE) && ({1'b0, coef_addr_i} < FRAME_END);

  // NOTE: the coefficient RAM has no reset so it maps onto plain RAM; contents are defined by software loads.
  always_ff @(posedge clk) begin
    if (coef_wr) begin
      coef_mem[coef_addr_i[CA_W-1:0]] <= coef_data_i;
    end
  end

  assign coef_rd = coef_mem[idx_q[CA_W-1:0]];
  assign product = PW'(frame_sample_i) * PW'(coef_rd);

`ifdef WINDOW_ROUND_SAT_EN
  localparam logic signed [PW:0] ROUND_BIAS = (PW+1)'(1) << (COEF_FRAC - 1);
  localparam logic signed [PW:0] SAT_MAX    = (PW+1)'({1'b0, {(SAMPLE_WIDTH-1){1'b1}}});
  localparam logic signed [PW:0] SAT_MIN    = ~SAT_MAX;

  logic signed [PW:0] rounded;

  always_comb begin
    rounded = ((PW+1)'(product) + ROUND_BIAS) >>> COEF_FRAC;
    if (rounded > SAT_MAX) begin
      win_sample = SAT_MAX[SAMPLE_WIDTH-1:0];
    end else if (rounded < SAT_MIN) begin
      win_sample = SAT_MIN[SAMPLE_WIDTH-1:0];
    end else begin
      win_sample = rounded[SAMPLE_WIDTH-1:0];
    end
  end
`else
  assign win_sample = SAMPLE_WIDTH'(product >>> COEF_FRAC);
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      pending_q    <= 1'b0;
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      out_sample_q <= out_sample_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
    end
  end

  // NOTE: every variable gets a hold default first so no branch can infer a latch.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pending_d    = pending_q;
    out_sample_d = out_sample_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;

    if (out_xfer) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
    if (rd_en_o) begin
      pending_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          idx_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // The output register is guaranteed free here: a read is only issued when it is.
        if (pending_q && sample_valid_i) begin
          pending_d    = 1'b0;
          out_sample_d = win_sample;
          out_valid_d  = 1'b1;
          out_last_d   = (idx_q == PAD_LAST);
          idx_d        = idx_q + IDX_W'(1);
          if (idx_q == FETCH_LAST) begin
            state_d = (FRAME_LEN == NFFT_SIZE) ? S_DRAIN : S_PAD;
          end
        end
      end
      S_PAD: begin
        if (out_free) begin
          out_sample_d = '0;
          out_valid_d  = 1'b1;
          out_last_d   = (idx_q == PAD_LAST);
          idx_d        = idx_q + IDX_W'(1);
          if (idx_q == PAD_LAST) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (out_free) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    busy_o      = (state_q != S_IDLE);
    done_o      = (state_q == S_DONE);
    rd_en_o     = (state_q == S_FETCH) && !pending_q && out_free;
    frame_ptr_o = rd_en_o ? idx_q[PTR_W-1:0] : '0;
  end

  assign out_sample_o = out_sample_q;
  assign out_valid_o  = out_valid_q;
  assign out_last_o   = out_last_q;

endmodule

// File: tb/tb_window_apply.sv
// Self-checking bench for window_apply: a frame-buffer responder, a ready driver and one
// compare process scoring every transfer against a queue built from plain arithmetic.
module tb_window_apply;

  localparam int SW = 16;
  localparam int CW = 16;
  localparam int CF = 15;
  localparam int FL = 306;
  localparam int NF = 512;
  localparam int PW = $clog2(NF);
  localparam int BUDGET = 6000;

  logic                 clk;
  logic                 rst_n;
  logic                 start_i;
  logic                 busy_o;
  logic                 rd_en_o;
  logic [PW-1:0]        frame_ptr_o;
  logic                 sample_valid_i;
  logic signed [SW-1:0] frame_sample_i;
  logic                 coef_we_i;
  logic [PW-1:0]        coef_addr_i;
  logic signed [CW-1:0] coef_data_i;
  logic signed [SW-1:0] out_sample_o;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic                 out_last_o;
  logic                 done_o;

  window_apply #(
    .SAMPLE_WIDTH(SW), .COEF_WIDTH(CW), .COEF_FRAC(CF),
    .FRAME_LEN(FL), .NFFT_SIZE(NF), .PTR_W(PW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .busy_o(busy_o),
    .rd_en_o(rd_en_o), .frame_ptr_o(frame_ptr_o),
    .sample_valid_i(sample_valid_i), .frame_sample_i(frame_sample_i),
    .coef_we_i(coef_we_i), .coef_addr_i(coef_addr_i), .coef_data_i(coef_data_i),
    .out_sample_o(out_sample_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_last_o(out_last_o), .done_o(done_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic signed [SW-1:0] frame_mem [NF];
  logic signed [CW-1:0] coef_m [FL];
  logic signed [SW-1:0] exp_q [$];
  logic signed [SW-1:0] got [NF];
  int                   xfer_cyc [NF];

  int cyc_cnt = 0;
  int xfer_cnt = 0;
  int next_rd_idx = 0;
  int rd_cnt = 0;
  int rd_delay = 1;
  int ready_mode = 0;
  int stall_left = 0;
  bit stalled = 0;
  bit done_seen = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: exact product, then either round+clamp or truncate+wrap.
  function automatic logic signed [SW-1:0] model(input logic signed [SW-1:0] s,
                                                 input logic signed [CW-1:0] c);
    longint p;
    longint hi;
    longint lo;
    p  = longint'(s) * longint'(c);
    hi = (longint'(1) <<< (SW - 1)) - 1;
    lo = -hi - 1;
`ifdef WINDOW_ROUND_SAT_EN
    p = (p + (longint'(1) <<< (CF - 1))) >>> CF;
    if (p > hi) p = hi;
    else if (p < lo) p = lo;
`else
    p = p >>> CF;
`endif
    return p[SW-1:0];
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc_cnt++;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Frame buffer: answers each read rd_delay cycles later with the stored sample.
  initial begin : responder
    int p;
    forever begin
      @(negedge clk);
      if (rd_en_o) begin
        p = int'(frame_ptr_o);
        if (chk_en) check("read_ptr", p, next_rd_idx);
        next_rd_idx++;
        rd_cnt++;
        repeat (rd_delay) @(posedge clk);
        #1;
        sample_valid_i = 1'b1;
        frame_sample_i = frame_mem[p];
        @(posedge clk);
        #1;
        sample_valid_i = 1'b0;
        frame_sample_i = SW'($urandom);
      end
    end
  end

  // Downstream ready: always, random, or a single 5-cycle stall while index 10 is presented.
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0: out_ready_i = 1'b1;
      1: out_ready_i = ($urandom_range(0, 3) != 0);
      default: begin
        if (!stalled && out_valid_o && xfer_cnt == 10) begin
          stalled    = 1'b1;
          stall_left = 5;
        end
        if (stall_left > 0) begin
          out_ready_i = 1'b0;
          stall_left--;
        end else begin
          out_ready_i = 1'b1;
        end
      end
    endcase
  end

  initial begin : compare
    bit                   prev_stall;
    bit                   done_pending;
    logic signed [SW-1:0] prev_sample;
    logic                 prev_last;
    logic signed [SW-1:0] e;
    prev_stall   = 1'b0;
    done_pending = 1'b0;
    prev_sample  = '0;
    prev_last    = 1'b0;
    forever begin
      @(negedge clk);
      if (!chk_en) begin
        prev_stall   = 1'b0;
        done_pending = 1'b0;
      end else begin
        check("done_timing", done_o, done_pending);
        if (done_o) done_seen = 1'b1;
        check("rd_en_during_stall", rd_en_o && out_valid_o && !out_ready_i, 0);
        if (prev_stall) begin
          check("hold_valid", out_valid_o, 1);
          check("hold_sample", out_sample_o, prev_sample);
          check("hold_last", out_last_o, prev_last);
        end
        done_pending = 1'b0;
        if (out_valid_o && out_ready_i) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL extra_transfer: got transfer %0d, expected none", xfer_cnt);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("sample[%0d]", xfer_cnt), out_sample_o, e);
            check($sformatf("last[%0d]", xfer_cnt), out_last_o, xfer_cnt == NF - 1);
            got[xfer_cnt]      = out_sample_o;
            xfer_cyc[xfer_cnt] = cyc_cnt;
            xfer_cnt++;
            done_pending = (xfer_cnt == NF);
          end
        end
        prev_stall  = out_valid_o && !out_ready_i;
        prev_sample = out_sample_o;
        prev_last   = out_last_o;
      end
    end
  end

  task automatic load_coefs();
    for (int i = 0; i < FL; i++) begin
      @(posedge clk);
      #1;
      coef_we_i   = 1'b1;
      coef_addr_i = PW'(i);
      coef_data_i = coef_m[i];
    end
    @(posedge clk);
    #1;
    coef_we_i = 1'b0;
  endtask

  task automatic randomize_frame();
    for (int i = 0; i < FL; i++) begin
      case ($urandom_range(0, 7))
        0:       frame_mem[i] = -SW'(32768);
        1:       frame_mem[i] = SW'(32767);
        default: frame_mem[i] = SW'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       coef_m[i] = -CW'(32768);
        1:       coef_m[i] = CW'(32767);
        default: coef_m[i] = CW'($urandom);
      endcase
    end
  endtask

  // poke: mid-frame coefficient write and start pulse; abort: return once 100 samples moved.
  task automatic run_frame(input int rmode, input int dly, input bit poke, input bit abort);
    int cyc;
    exp_q.delete();
    for (int i = 0; i < NF; i++) begin
      exp_q.push_back((i < FL) ? model(frame_mem[i], coef_m[i]) : SW'(0));
    end
    xfer_cnt    = 0;
    next_rd_idx = 0;
    rd_cnt      = 0;
    rd_delay    = dly;
    ready_mode  = rmode;
    stalled     = 1'b0;
    stall_left  = 0;
    done_seen   = 1'b0;
    @(posedge clk);
    #1;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    cyc = 0;
    while (!done_seen && cyc < BUDGET) begin
      if (abort && xfer_cnt >= 100) return;
      @(posedge clk);
      #1;
      cyc++;
      if (poke && cyc == 20) begin
        coef_we_i   = 1'b1;
        coef_addr_i = PW'(5);
        coef_data_i = CW'(1234);
        start_i     = 1'b1;
      end else begin
        coef_we_i = 1'b0;
        start_i   = 1'b0;
      end
    end
    check("frame_completed", done_seen, 1);
    check("transfer_total", xfer_cnt, NF);
    check("read_total", rd_cnt, FL);
    check("queue_drained", exp_q.size(), 0);
    @(negedge clk);
    check("idle_after_done", busy_o, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_rd_en"}, rd_en_o, 0);
    check({tag, "_ptr"}, frame_ptr_o, 0);
    check({tag, "_valid"}, out_valid_o, 0);
    check({tag, "_sample"}, out_sample_o, 0);
    check({tag, "_last"}, out_last_o, 0);
    check({tag, "_done"}, done_o, 0);
  endtask

  initial begin
    rst_n          = 1'b0;
    start_i        = 1'b0;
    sample_valid_i = 1'b0;
    frame_sample_i = '0;
    coef_we_i      = 1'b0;
    coef_addr_i    = '0;
    coef_data_i    = '0;
    out_ready_i    = 1'b1;
    for (int i = 0; i < NF; i++) frame_mem[i] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Constant window and constant samples.
    for (int i = 0; i < FL; i++) begin
      coef_m[i]    = CW'(32767);
      frame_mem[i] = SW'(1000);
    end
    load_coefs();
    run_frame(0, 1, 0, 0);
`ifdef WINDOW_ROUND_SAT_EN
    check("const_first", got[0], 1000);
    check("const_lastwin", got[FL-1], 1000);
`else
    check("const_first", got[0], 999);
    check("const_lastwin", got[FL-1], 999);
`endif
    check("const_firstpad", got[FL], 0);
    check("const_lastpad", got[NF-1], 0);
    check("fetch_rate", xfer_cyc[FL-1] - xfer_cyc[0], 2 * (FL - 1));
    check("pad_rate", xfer_cyc[NF-1] - xfer_cyc[FL-1], NF - FL);

    // Most-negative times most-negative.
    coef_m[0]    = -CW'(32768);
    frame_mem[0] = -SW'(32768);
    load_coefs();
    run_frame(0, 1, 0, 0);
`ifdef WINDOW_ROUND_SAT_EN
    check("extreme_product", got[0], 32767);
`else
    check("extreme_product", got[0], -32768);
`endif

    randomize_frame();
    load_coefs();
    run_frame(1, 1, 0, 0);
    run_frame(2, 1, 0, 0);
    check("stall_happened", stalled, 1);
    run_frame(0, 3, 0, 0);
    run_frame(1, 2, 0, 0);

    // Writes and start pulses while busy must be ignored.
    frame_mem[5] = SW'(12345);
    coef_m[5]    = -CW'(20000);
    load_coefs();
    run_frame(0, 1, 1, 0);
    run_frame(1, 1, 0, 0);
    check("coef5_kept", got[5], model(SW'(12345), -CW'(20000)));

    // Abort mid-frame, then restart cleanly from index 0.
    randomize_frame();
    load_coefs();
    run_frame(0, 1, 0, 1);
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_done_after_abort", done_o, 0);
      check("idle_after_abort", busy_o, 0);
    end
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    run_frame(1, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
